// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, imem request/response tracking, in-order PC-tagged instruction buffer.
// Latency: a response reaches if_* the cycle after imem_rsp_valid; requests issue from registered state.
// Backpressure: requests stop once buffered + outstanding fetches reach BUF_DEPTH; the head holds while if_ready is low.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [4:0]      if_opcode
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(BUF_DEPTH);
    localparam logic [CW:0]     ONE_W   = (CW + 1)'(1);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [AW-1:0]   ONE_P   = AW'(1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_M = ~XLEN'(3);

    // Architectural fetch state
    logic [XLEN-1:0] fetch_pc;      // next address to request
    logic [XLEN-1:0] rsp_pc;        // PC that the next kept response belongs to
    logic [CW-1:0]   count;         // valid buffer entries
    logic [CW-1:0]   outstanding;   // accepted requests whose data will be kept
    logic [CW-1:0]   discard;       // accepted requests whose data must be dropped

    // Circular buffer storage
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [31:0]     buf_instr [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc    [BUF_DEPTH];

    // Next-state helpers
    logic [CW:0]     in_flight;
    logic [CW:0]     stale_sum;
    logic [CW:0]     stale_adj;
    logic [XLEN-1:0] redirect_aligned;
    logic            req_fire;
    logic            rsp_take;
    logic            pop;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   discard_nxt;

    assign in_flight        = {1'b0, count} + {1'b0, outstanding};
    assign stale_sum        = {1'b0, discard} + {1'b0, outstanding};
    assign redirect_aligned = redirect_pc & ALIGN_M;

    // A redirect withdraws the request; the cap counts buffered plus kept-outstanding fetches.
    assign imem_req_valid = !rst && !redirect_valid && (in_flight < DEPTH_W);
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Only a response owed to the current stream is kept; stale and spurious ones are dropped.
    assign rsp_take = imem_rsp_valid && !redirect_valid && (discard == '0) && (outstanding != '0);

    // Decode-side view straight from buffer storage (no path from imem_rsp)
    assign if_valid  = (count != '0);
    assign if_instr  = buf_instr[head];
    assign if_pc     = buf_pc[head];
    assign if_opcode = if_instr[6:2];
    assign pop       = if_valid && if_ready && !redirect_valid;

    // Counter next-state; a redirect turns every outstanding fetch into one to discard
    always_comb begin
        count_nxt       = count;
        outstanding_nxt = outstanding;
        discard_nxt     = discard;
        stale_adj       = stale_sum;
        if (redirect_valid) begin
            if (imem_rsp_valid && (stale_sum != '0)) begin
                stale_adj = stale_sum - ONE_W;
            end
            count_nxt       = '0;
            outstanding_nxt = '0;
            discard_nxt     = CW'(stale_adj);
        end else begin
            if (imem_rsp_valid && (discard != '0)) begin
                discard_nxt = discard - ONE_C;
            end
            if (req_fire && !rsp_take) begin
                outstanding_nxt = outstanding + ONE_C;
            end else if (!req_fire && rsp_take) begin
                outstanding_nxt = outstanding - ONE_C;
            end
            if (rsp_take && !pop) begin
                count_nxt = count + ONE_C;
            end else if (!rsp_take && pop) begin
                count_nxt = count - ONE_C;
            end
        end
    end

    // PCs, counters and buffer pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            count       <= count_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_take) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                    tail   <= tail + ONE_P;
                end
                if (pop) begin
                    head <= head + ONE_P;
                end
            end
        end
    end

    // Buffer storage; cleared on reset so the idle outputs read as instr 0 at RESET_PC
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= RESET_PC;
            end
        end else if (rsp_take) begin
            buf_instr[tail] <= imem_rsp_data;
            buf_pc[tail]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: random memory/decode/redirect traffic against a stream-level model.
// Expected decode stream is queued by the stimulus side; an independent monitor pops and compares.
// Memory responds in order with random latency; redirects mark pending fetches stale.
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  if_opcode;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_opcode(if_opcode)
    );

    typedef struct { logic [31:0] addr; bit stale; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mreq_t       mq[$];      // requests accepted by memory, oldest first
    exp_t        exq[$];     // instructions decode should still see, in order
    logic [31:0] exp_fetch;  // address the next request must carry
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          spurious = 0;
    bit          redir_done = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    function automatic int nonstale();
        int n = 0;
        foreach (mq[i]) if (!mq[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of traffic: drive at negedge, check request side at +1, update model at +3
    task automatic step(input int rdy_pct, input int irdy_pct, input int rsp_pct, input int redir_pct,
                        input int lmin, input int lmax, input bit force_redir, input logic [31:0] force_pc);
        bit    rsp;
        bit    fire;
        mreq_t e;
        @(negedge clk);
        rst = 1'b0;
        rsp = (mq.size() != 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
        if (!rsp && spurious) begin
            imem_rsp_valid = 1'b1;
            spurious = 0;
        end
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if ((force_redir || ($urandom_range(99) < redir_pct)) && (mq.size() - int'(rsp) <= DEPTH)) begin
            redirect_valid = 1'b1;
            if (force_redir) redirect_pc = force_pc;
            redir_done = 1;
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        if_ready       = ($urandom_range(99) < irdy_pct);
        #1;
        check("req_valid", imem_req_valid, !redirect_valid && ((exq.size() + nonstale()) < DEPTH));
        fire = imem_req_valid && imem_req_ready;
        if (fire) check("imem_addr", imem_addr, exp_fetch);
        #2;
        if (rsp) begin
            e = mq.pop_front();
            if (!redirect_valid && !e.stale) exq.push_back('{e.addr, mem_word(e.addr)});
        end
        if (fire) begin
            mq.push_back('{exp_fetch, redirect_valid, cyc + $urandom_range(lmax, lmin)});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect_valid) begin
            foreach (mq[i]) mq[i].stale = 1;
            exq.delete();
            exp_fetch = redirect_pc & ~32'h3;
        end
        cyc++;
    endtask

    task automatic phase(input int n, input int rdy, input int irdy, input int rspp, input int redir,
                         input int lmin, input int lmax);
        for (int k = 0; k < n; k++) step(rdy, irdy, rspp, redir, lmin, lmax, 1'b0, '0);
    endtask

    task automatic force_redirect(input logic [31:0] pc, input int lat);
        redir_done = 0;
        for (int k = 0; k < 20 && !redir_done; k++) step(100, 100, 100, 0, lat, lat, 1'b1, pc);
        checks++;
        if (!redir_done) begin
            errors++;
            $display("FAIL redirect_issue: got none expected redirect to %h", pc);
        end
    endtask

    // Reset held for n cycles; late responses from abandoned fetches are still delivered
    task automatic do_reset(input int n);
        bit rsp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst            = 1'b1;
            redirect_valid = 1'b0;
            if_ready       = 1'($urandom);
            imem_req_ready = 1'($urandom);
            rsp            = (mq.size() != 0);
            imem_rsp_valid = rsp;
            imem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'h0;
            if (rsp) void'(mq.pop_front());
            #1;
            check("rst_req_valid", imem_req_valid, 1'b0);
            if (i > 0) begin
                check("rst_if_valid", if_valid, 1'b0);
                check("rst_if_instr", if_instr, 32'h0);
                check("rst_if_pc", if_pc, RESET_PC);
            end
            cyc++;
        end
        mq.delete();
        exq.delete();
        exp_fetch = RESET_PC;
        spurious  = 1;
    endtask

    // Monitor: compares every decode handshake against the head of the expected stream
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("if_valid", if_valid, exq.size() != 0);
                if (if_valid && if_ready && !redirect_valid && exq.size() != 0) begin
                    x = exq.pop_front();
                    check("if_pc", if_pc, x.pc);
                    check("if_instr", if_instr, x.instr);
                    check("if_opcode", if_opcode, x.instr[6:2]);
                end
            end
        end
    end

    initial begin
        exp_fetch = RESET_PC;
        do_reset(3);
        phase(40, 100, 100, 100, 0, 1, 1);       // 1-cycle memory, decode always ready
        phase(12, 100, 0, 100, 0, 1, 1);         // decode stalled: cap must stop requests
        phase(20, 100, 100, 100, 0, 1, 1);       // drain and resume
        phase(4, 100, 100, 100, 0, 3, 3);        // build up outstanding fetches
        force_redirect(32'h0000_0100, 3);
        phase(20, 100, 100, 100, 0, 3, 3);
        force_redirect(32'h0000_0203, 1);
        phase(15, 100, 100, 100, 0, 1, 1);
        force_redirect(32'hFFFF_FFF8, 1);        // fetch PC wraps through zero
        phase(15, 100, 100, 100, 0, 1, 2);
        force_redirect(32'h0000_0400, 2);        // back-to-back redirects
        force_redirect(32'h0000_0801, 2);
        phase(20, 100, 50, 100, 0, 1, 3);
        phase(200, 70, 60, 70, 5, 1, 4);
        phase(6, 100, 30, 100, 0, 3, 3);
        do_reset(3);                              // reset with fetches in flight
        phase(20, 100, 100, 100, 0, 1, 1);
        phase(300, 50, 50, 60, 8, 1, 5);
        phase(300, 90, 90, 90, 3, 1, 2);
        phase(30, 100, 100, 100, 0, 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
